rsa_run_host: RTL and testbench

Host-side run controller for the RSA pipeline CPU top; it is the driving/collecting end of the start/EndFlag run interface.
- On a host request, pulses start to the CPU and waits for EndFlag, with a timeout.
- Reads NUM_WORDS result words from CPU data memory through the ReadDataOut read port.
- Streams the words to the host over a valid/ready interface.
- Sits between the host/bench and top, replacing hand-driven start stimulus.

---
 rtl/rsa_host_pkg.sv | 24 ++
 rtl/rsa_timeout_cnt.sv | 28 ++
 rtl/rsa_run_host.sv | 167 ++++++++++++++++
 tb/tb_rsa_run_host.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_host_pkg.sv
// Shared state encoding and default sizing for the RSA host run controller.
// Pure declarations: no latency, no backpressure.
package rsa_host_pkg;

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_ADDR_W      = 10;
    localparam int DEF_NUM_WORDS   = 8;
    localparam int DEF_RESULT_BASE = 0;
    localparam int DEF_TIMEOUT_CYC = 100000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        RUN,
        READ,
        WAIT,
        PUSH,
        DONE
`ifdef RSA_RUN_HOST_CHECKSUM_EN
        , CKSUM
`endif
    } state_t;

endpackage

// File: rtl/rsa_timeout_cnt.sv
// Loadable down-counter; expire flags the last enabled cycle (count at zero).
// Single-cycle update, no backpressure; load has priority over decrement.
module rsa_timeout_cnt #(
    parameter int W = 17
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         expire
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign expire = en && (cnt == '0);

endmodule

// File: rtl/rsa_run_host.sv
// Host run controller: start pulse, EndFlag wait with timeout, NUM_WORDS reads streamed out; RSA_RUN_HOST_CHECKSUM_EN adds an XOR checksum beat.
// EndFlag sample to first out_valid is 3 cycles, 1 word per 3 cycles; out_ready low stalls in PUSH forever with data held.
module rsa_run_host
    import rsa_host_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int NUM_WORDS   = DEF_NUM_WORDS,
    parameter int RESULT_BASE = DEF_RESULT_BASE,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              run_req,
    output logic              busy,
    output logic              start,
    input  logic              EndFlag,
    input  logic              FlagZero,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] ReadDataOut,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              done,
    output logic              timeout_err,
    output logic              zero_flag
);

    localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(RESULT_BASE);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_WORDS - 1);
    // Loading TIMEOUT_CYC-2 makes timeout_err appear TIMEOUT_CYC cycles after the start pulse.
    localparam logic [CNT_W-1:0]  TMO_LOAD = CNT_W'(TIMEOUT_CYC - 2);

    state_t            state;
    logic [ADDR_W-1:0] idx;
    logic              is_last;
    logic              tmo_expire;
`ifdef RSA_RUN_HOST_CHECKSUM_EN
    logic [DATA_W-1:0] acc;
`endif

    assign is_last = (idx == LAST_IDX);

    rsa_timeout_cnt #(.W(CNT_W)) u_tmo (
        .clk      (clk),
        .reset    (reset),
        .load     (state == START),
        .load_val (TMO_LOAD),
        .en       ((state == RUN) && !EndFlag),
        .expire   (tmo_expire)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            idx         <= '0;
            busy        <= 1'b0;
            start       <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            zero_flag   <= 1'b0;
`ifdef RSA_RUN_HOST_CHECKSUM_EN
            acc         <= '0;
`endif
        end else begin
            start <= 1'b0;
            rd_en <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (run_req) begin
                        state       <= START;
                        start       <= 1'b1;
                        busy        <= 1'b1;
                        timeout_err <= 1'b0;
                        zero_flag   <= 1'b0;
                    end
                end
                START: begin
                    // EndFlag is not looked at here: it may still be high from the previous run.
                    state <= RUN;
`ifdef RSA_RUN_HOST_CHECKSUM_EN
                    acc   <= '0;
`endif
                end
                RUN: begin
                    if (EndFlag) begin
                        zero_flag <= FlagZero;
                        idx       <= '0;
                        rd_en     <= 1'b1;
                        rd_addr   <= BASE;
                        state     <= READ;
                    end else if (tmo_expire) begin
                        timeout_err <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                READ: begin
                    state <= WAIT;
                end
                WAIT: begin
                    out_data  <= ReadDataOut;
                    out_valid <= 1'b1;
`ifdef RSA_RUN_HOST_CHECKSUM_EN
                    out_last  <= 1'b0;
`else
                    out_last  <= is_last;
`endif
                    state     <= PUSH;
                end
                PUSH: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
`ifdef RSA_RUN_HOST_CHECKSUM_EN
                        acc <= acc ^ out_data;
`endif
                        if (is_last) begin
`ifdef RSA_RUN_HOST_CHECKSUM_EN
                            out_valid <= 1'b1;
                            out_data  <= acc ^ out_data;
                            out_last  <= 1'b1;
                            state     <= CKSUM;
`else
                            done      <= 1'b1;
                            state     <= DONE;
`endif
                        end else begin
                            idx     <= idx + 1'b1;
                            rd_en   <= 1'b1;
                            rd_addr <= BASE + idx + 1'b1;
                            state   <= READ;
                        end
                    end
                end
`ifdef RSA_RUN_HOST_CHECKSUM_EN
                CKSUM: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        done      <= 1'b1;
                        state     <= DONE;
                    end
                end
`endif
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rsa_run_host.sv
// Scoreboard bench for rsa_run_host: two instances (8 words at base 0, 4 words at base 1022), both with a 50-cycle timeout.
module tb_rsa_run_host;

    localparam int DW  = 32;
    localparam int AW  = 10;
    localparam int TMO = 50;

    typedef struct { int inst; logic [DW-1:0] data; logic last; } beat_t;
    typedef struct { int inst; logic [AW-1:0] addr; } raddr_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n [2];
    logic          run_req [2];
    logic          end_flag [2];
    logic          flag_zero [2];
    logic          out_ready [2];
    logic          busy [2];
    logic          start [2];
    logic          rd_en [2];
    logic [AW-1:0] rd_addr [2];
    logic [DW-1:0] rdata [2];
    logic          out_valid [2];
    logic [DW-1:0] out_data [2];
    logic          out_last [2];
    logic          done [2];
    logic          timeout_err [2];
    logic          zero_flag [2];

    logic [DW-1:0] mem [2][1024];

    int tests = 0;
    int fails = 0;
    beat_t  exp_q[$];
    raddr_t addr_q[$];
    int start_cnt [2] = '{0, 0};
    int done_cnt  [2] = '{0, 0};
    int vld_cnt   [2] = '{0, 0};
    logic          prev_stall [2] = '{1'b0, 1'b0};
    logic          prev_start [2] = '{1'b0, 1'b0};
    logic [DW-1:0] prev_data  [2];
    logic          prev_last  [2];
    logic [7:0]    lfsr = 8'hA5;

    rsa_run_host #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(8), .RESULT_BASE(0), .TIMEOUT_CYC(TMO)) u_a (
        .clk(clk), .reset(rst_n[0]), .run_req(run_req[0]), .busy(busy[0]), .start(start[0]),
        .EndFlag(end_flag[0]), .FlagZero(flag_zero[0]), .rd_en(rd_en[0]), .rd_addr(rd_addr[0]),
        .ReadDataOut(rdata[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
        .out_data(out_data[0]), .out_last(out_last[0]), .done(done[0]),
        .timeout_err(timeout_err[0]), .zero_flag(zero_flag[0]));

    rsa_run_host #(.DATA_W(DW), .ADDR_W(AW), .NUM_WORDS(4), .RESULT_BASE(1022), .TIMEOUT_CYC(TMO)) u_b (
        .clk(clk), .reset(rst_n[1]), .run_req(run_req[1]), .busy(busy[1]), .start(start[1]),
        .EndFlag(end_flag[1]), .FlagZero(flag_zero[1]), .rd_en(rd_en[1]), .rd_addr(rd_addr[1]),
        .ReadDataOut(rdata[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
        .out_data(out_data[1]), .out_last(out_last[1]), .done(done[1]),
        .timeout_err(timeout_err[1]), .zero_flag(zero_flag[1]));

    // Data memory with one cycle of read latency.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rd_en[k]) rdata[k] <= mem[k][rd_addr[k]];
        end
    end

    task automatic check(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s [u%0d]: got 0x%0h, expected 0x%0h", name, k, act, exp);
        end
    endtask

    task automatic check_outs_zero(input int k);
        check("rst_ctrl", k, {24'b0, busy[k], start[k], rd_en[k], out_valid[k], out_last[k],
                              done[k], timeout_err[k], zero_flag[k]}, 32'h0);
        check("rst_rd_addr", k, {22'b0, rd_addr[k]}, 32'h0);
        check("rst_out_data", k, out_data[k], 32'h0);
    endtask

    // Monitor: samples 1 ns after the falling edge, after the bench has driven its inputs.
    always begin : monitor
        beat_t  b;
        raddr_t a;
        @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (start[k]) start_cnt[k]++;
            if (start[k] && prev_start[k]) begin
                tests++;
                fails++;
                $display("FAIL start_width [u%0d]: start high two cycles running", k);
            end
            if (done[k]) done_cnt[k]++;
            if (rd_en[k]) begin
                if (addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL rd_addr_extra [u%0d]: unexpected read of 0x%0h", k, rd_addr[k]);
                end else begin
                    a = addr_q.pop_front();
                    check("rd_inst", k, k, a.inst);
                    check("rd_addr", k, {22'b0, rd_addr[k]}, {22'b0, a.addr});
                end
            end
            if (out_valid[k]) begin
                vld_cnt[k]++;
                if (prev_stall[k]) begin
                    check("hold_data", k, out_data[k], prev_data[k]);
                    check("hold_last", k, {31'b0, out_last[k]}, {31'b0, prev_last[k]});
                end
                if (out_ready[k]) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL beat_extra [u%0d]: unexpected beat 0x%0h", k, out_data[k]);
                    end else begin
                        b = exp_q.pop_front();
                        check("beat_inst", k, k, b.inst);
                        check("beat_data", k, out_data[k], b.data);
                        check("beat_last", k, {31'b0, out_last[k]}, {31'b0, b.last});
                    end
                end
            end
            prev_stall[k] = out_valid[k] && !out_ready[k];
            prev_data[k]  = out_data[k];
            prev_last[k]  = out_last[k];
            prev_start[k] = start[k];
        end
    end

    task automatic push_exp(input int k, input int nwords, input int base);
        logic [DW-1:0] x;
        int a;
        x = '0;
        for (int i = 0; i < nwords; i++) begin
            a = (base + i) % 1024;
            addr_q.push_back('{k, AW'(a)});
`ifdef RSA_RUN_HOST_CHECKSUM_EN
            exp_q.push_back('{k, mem[k][a], 1'b0});
            x = x ^ mem[k][a];
`else
            exp_q.push_back('{k, mem[k][a], (i == nwords - 1)});
`endif
        end
`ifdef RSA_RUN_HOST_CHECKSUM_EN
        exp_q.push_back('{k, x, 1'b1});
`endif
    endtask

    // Returns at the falling edge of the start-pulse cycle.
    task automatic pulse_req(input int k);
        run_req[k] = 1'b1;
        @(negedge clk);
        run_req[k] = 1'b0;
        check("start_pulse", k, {31'b0, start[k]}, 32'h1);
    endtask

    // The CPU drops its stale EndFlag one cycle after start, raises it delay cycles after start.
    task automatic raise_flag(input int k, input int delay);
        @(negedge clk);
        end_flag[k] = 1'b0;
        repeat (delay - 1) @(negedge clk);
        end_flag[k] = 1'b1;
    endtask

    task automatic wait_done(input int k, input int budget, input bit rnd);
        int n;
        n = 0;
        while (!done[k] && n < budget) begin
            @(negedge clk);
            if (rnd) begin
                lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                out_ready[k] = lfsr[0];
            end
            n++;
        end
        check("done_seen", k, {31'b0, done[k]}, 32'h1);
        out_ready[k] = 1'b1;
    endtask

    task automatic end_checks(input int k, input int s0, input int d0);
        repeat (2) @(negedge clk);
        check("start_count", k, start_cnt[k] - s0, 1);
        check("done_count", k, done_cnt[k] - d0, 1);
        check("busy_idle", k, {31'b0, busy[k]}, 32'h0);
        check("beats_left", k, exp_q.size(), 0);
        check("reads_left", k, addr_q.size(), 0);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int s0, d0, v0, n, seen;
        for (int k = 0; k < 2; k++) begin
            rst_n[k] = 1'b0; run_req[k] = 1'b0; end_flag[k] = 1'b0;
            flag_zero[k] = 1'b0; out_ready[k] = 1'b1;
        end
        for (int i = 0; i < 8; i++) mem[0][i] = 32'(i + 1);
        @(negedge clk);
        @(negedge clk);
        check_outs_zero(0);
        check_outs_zero(1);
        #2;
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // 1: basic 8-word run, EndFlag 40 cycles after start
        @(negedge clk);
        flag_zero[0] = 1'b1;
        push_exp(0, 8, 0);
        s0 = start_cnt[0]; d0 = done_cnt[0];
        pulse_req(0);
        raise_flag(0, 40);
        n = 0;
        while (!out_valid[0] && n < 10) begin @(negedge clk); n++; end
        check("endflag_to_valid", 0, n, 3);
        wait_done(0, 200, 1'b0);
        end_checks(0, s0, d0);
        check("zero_flag_1", 0, {31'b0, zero_flag[0]}, 32'h1);

        // 2: timeout; EndFlag is stale-high during START, then never rises
        flag_zero[0] = 1'b0;
        s0 = start_cnt[0]; d0 = done_cnt[0]; v0 = vld_cnt[0];
        pulse_req(0);
        @(negedge clk);
        end_flag[0] = 1'b0;
        n = 1;
        while (!timeout_err[0] && n < 200) begin @(negedge clk); n++; end
        check("timeout_cycle", 0, n, TMO);
        check("timeout_busy", 0, {31'b0, busy[0]}, 32'h0);
        repeat (3) @(negedge clk);
        check("timeout_no_valid", 0, vld_cnt[0] - v0, 0);
        check("timeout_no_done", 0, done_cnt[0] - d0, 0);
        check("timeout_sticky", 0, {31'b0, timeout_err[0]}, 32'h1);
        push_exp(0, 8, 0);
        s0 = start_cnt[0]; d0 = done_cnt[0];
        pulse_req(0);
        check("timeout_cleared", 0, {31'b0, timeout_err[0]}, 32'h0);
        raise_flag(0, 5);
        wait_done(0, 200, 1'b0);
        end_checks(0, s0, d0);
        check("zero_flag_0", 0, {31'b0, zero_flag[0]}, 32'h0);

        // 3+4: 4 words with address wrap 1022,1023,0,1 and pseudo-random out_ready
        mem[1][1022] = 32'h1111_0001; mem[1][1023] = 32'h2222_0002;
        mem[1][0]    = 32'h3333_0003; mem[1][1]    = 32'h4444_0004;
        push_exp(1, 4, 1022);
        s0 = start_cnt[1]; d0 = done_cnt[1];
        pulse_req(1);
        raise_flag(1, 6);
        wait_done(1, 400, 1'b1);
        end_checks(1, s0, d0);

        // 5: reset while word 3 is held in PUSH, then a clean run from word 0
        for (int i = 0; i < 8; i++) mem[0][i] = 32'hA0 + 32'(i);
        for (int i = 0; i < 3; i++) addr_q.push_back('{0, AW'(i)});
        exp_q.push_back('{0, 32'hA0, 1'b0});
        exp_q.push_back('{0, 32'hA1, 1'b0});
        pulse_req(0);
        raise_flag(0, 3);
        seen = 0; n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (out_valid[0]) begin
                if (seen == 2) break;
                seen++;
            end
        end
        out_ready[0] = 1'b0;
        check("reach_word3", 0, {31'b0, out_valid[0]}, 32'h1);
        check("word3_data", 0, out_data[0], 32'hA2);
        @(negedge clk);
        s0 = start_cnt[0];
        #2;
        rst_n[0] = 1'b0;
        #1;
        check_outs_zero(0);
        check("pre_reset_beats", 0, exp_q.size(), 0);
        check("pre_reset_reads", 0, addr_q.size(), 0);
        exp_q.delete();
        addr_q.delete();
        @(negedge clk);
        rst_n[0] = 1'b1;
        out_ready[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("no_start_on_reset", 0, start_cnt[0] - s0, 0);
        for (int i = 0; i < 8; i++) mem[0][i] = 32'hB0 + 32'(i);
        push_exp(0, 8, 0);
        s0 = start_cnt[0]; d0 = done_cnt[0];
        pulse_req(0);
        raise_flag(0, 4);
        wait_done(0, 200, 1'b0);
        end_checks(0, s0, d0);

`ifdef RSA_RUN_HOST_CHECKSUM_EN
        // 6: 0xA ^ 0x5 ^ 0xF ^ 0x0 = 0x0 on the extra beat
        mem[1][1022] = 32'hA; mem[1][1023] = 32'h5; mem[1][0] = 32'hF; mem[1][1] = 32'h0;
        addr_q.push_back('{1, 10'd1022}); addr_q.push_back('{1, 10'd1023});
        addr_q.push_back('{1, 10'd0});    addr_q.push_back('{1, 10'd1});
        exp_q.push_back('{1, 32'hA, 1'b0}); exp_q.push_back('{1, 32'h5, 1'b0});
        exp_q.push_back('{1, 32'hF, 1'b0}); exp_q.push_back('{1, 32'h0, 1'b0});
        exp_q.push_back('{1, 32'h0, 1'b1});
        s0 = start_cnt[1]; d0 = done_cnt[1];
        pulse_req(1);
        raise_flag(1, 4);
        wait_done(1, 200, 1'b0);
        end_checks(1, s0, d0);
`endif

        repeat (3) @(negedge clk);
        check("final_beats_left", 0, exp_q.size(), 0);
        check("final_reads_left", 0, addr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
